// File: rtl/pipe_addsub_pkg.sv
// Shared types and configuration helpers for the pipelined adder/subtractor.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result valid-ready streams of pipe_addsub.
interface pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/pipe_addsub_cla_chunk.sv
// Combinational CHUNK-bit carry-lookahead slice; also exposes the carry into
// its MSB so the final stage can form the signed-overflow flag.
module cla_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;
  logic             grp_g;
  logic             grp_p;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the group generate/propagate of bits [i:0] applied to cin.
  always_comb begin
    c     = '0;
    grp_g = 1'b0;
    grp_p = 1'b1;
    c[0]  = cin;
    for (int i = 0; i < CHUNK; i++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int j = 0; j <= i; j++) begin
        grp_g = g[j] | (p[j] & grp_g);
        grp_p = grp_p & p[j];
      end
      c[i+1] = grp_g | (grp_p & cin);
    end
  end

  assign sum      = p ^ c[CHUNK-1:0];
  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit lookahead per stage,
// carries passed between stages through registers, global valid/ready stall.
module pipe_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic          clk,
  input logic          rst_n,
  pipe_addsub_if.slave bus
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipe_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  op_e op;
  logic adv;

  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_nx;
  logic [STAGES-1:0]            c_q, v_q, c_in, v_in;
  logic [STAGES-1:0][CHUNK-1:0] sum_c;
  logic [STAGES-1:0]            cout_c, cmsb_c;
  logic                         ovf_q, zero_q;
  logic                         unused_bits;

  assign op  = op_e'(bus.in_op);
  assign adv = ~v_q[LAST] | bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_in[k] = bus.in_a;
      assign b_in[k] = (op == OP_SUB) ? ~bus.in_b : bus.in_b;
      assign c_in[k] = (op == OP_SUB) ? 1'b1 : bus.in_cin;
      assign s_in[k] = '0;
      assign v_in[k] = bus.in_valid;
    end else begin : g_body
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    cla_chunk #(.CHUNK(CHUNK)) u_cla (
      .a        (a_in[k][k*CHUNK +: CHUNK]),
      .b        (b_in[k][k*CHUNK +: CHUNK]),
      .cin      (c_in[k]),
      .sum      (sum_c[k]),
      .cout     (cout_c[k]),
      .c_msb_in (cmsb_c[k])
    );

    // Bits at and above this chunk are still zero in the partial sum.
    assign s_nx[k] = s_in[k] | (WIDTH'(sum_c[k]) << (k * CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      c_q    <= '0;
      v_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      a_q    <= a_in;
      b_q    <= b_in;
      s_q    <= s_nx;
      c_q    <= cout_c;
      v_q    <= v_in;
      ovf_q  <= cout_c[LAST] ^ cmsb_c[LAST];
      zero_q <= ~|s_nx[LAST];
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[LAST];
  assign bus.out_sum   = s_q[LAST];
  assign bus.out_cout  = c_q[LAST];
  assign bus.out_ovf   = ovf_q;
  assign bus.out_zero  = zero_q;

  // Already-consumed operand slices are deliberately left dangling.
  assign unused_bits = ^{a_q, b_q, cmsb_c};

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined adder/subtractor that splits a WIDTH-bit operation into STAGES = WIDTH/CHUNK carry-lookahead chunks, one chunk per pipeline stage. The carry ripples between stages through registers, so the clock period is bounded by one CHUNK-bit lookahead. It is the width-generic, handshaked successor to the 8-bit ripple and lookahead adders, and adds subtract mode plus status flags. It sits between an operand source and a result consumer, both using valid/ready streams.

## Interface
- `WIDTH`, 32: operand/result width. Must be a multiple of CHUNK.
- `CHUNK`, 8: bits resolved per stage, ≥1. STAGES = WIDTH/CHUNK. CHUNK == WIDTH gives a single stage.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_cin`  in  1  carry-in, used in add mode only.
- `in_op`  in  1  0 = ADD, 1 = SUB.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  WIDTH  result.
- `out_cout`  out  1  carry out. In SUB, 1 means no borrow (A ≥ B unsigned).
- `out_ovf`  out  1  two's-complement signed overflow.
- `out_zero`  out  1  out_sum == 0.

## Operation
- **Operand transform:**
  - ADD: B' = in_b, c0 = in_cin.
  - SUB: B' = ~in_b, c0 = 1. in_cin is ignored.
- **Stage k (0..STAGES-1):**
  - Computes bits [k·CHUNK +: CHUNK] with chunk generate/propagate lookahead, using the registered carry from stage k-1 (stage 0 uses c0).
  - Registers the partial sum (lower bits), the unprocessed upper slices of A/B', the chunk carry-out, and a valid bit.
- **Final stage flags:**
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero = ~|sum.
- **Arithmetic:** all modulo 2^WIDTH. No saturation.
- **Handshake:**
  - Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv, combinational from out_valid and out_ready only. It does not depend on in_valid.
  - A beat is accepted on a clock edge when in_valid & in_ready.
  - While adv = 0, every stage register holds, including valid bits.
  - Bubbles are not compressed. An empty stage still shifts only when adv = 1.
  - out_* fields are stable while out_valid & ~out_ready.
- **Reset:**
  - All stage valid bits, out_valid, out_sum, out_cout, out_ovf and out_zero are cleared to 0 asynchronously.
  - Deassertion is synchronised externally.
  - Reset mid-operation discards every in-flight beat. No partial result is emitted.

## Timing
- **Latency:** a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, i.e. STAGES register stages including the output register.
- **Throughput:** one beat per cycle while out_ready = 1.
- **Simultaneous accept and emit:** when the pipeline is full, accepting a beat and emitting a result in the same cycle is legal.
- **Back-pressure:** out_ready = 0 with out_valid = 1 stalls the pipeline in the same cycle, and in_ready drops combinationally.
- **Critical path:** one CHUNK lookahead plus flag logic in the last stage. There is no path from in_* to out_*.

## Structure
- **Package `adder_pkg`:**
  - `op_e` enum: OP_ADD = 1'b0, OP_SUB = 1'b1.
  - Elaboration-time checks: WIDTH % CHUNK == 0, CHUNK ≥ 1.
- **Sub-module `cla_chunk`:**
  - Parametrised by CHUNK; combinational.
  - Inputs: a, b, cin. Outputs: sum, cout, c_msb_in (carry into the chunk MSB, needed for ovf).
  - Instantiated STAGES times via generate.
- **Top:** pipeline registers and handshake logic.

## Test plan
Default parameters (WIDTH = 32, CHUNK = 8, STAGES = 4) unless stated.
- **ADD with cross-chunk carry:** ADD 0x0000_00FF + 0x0000_0001, cin = 0 → sum 0x0000_0100, cout 0, ovf 0, zero 0. out_valid appears 4 cycles after acceptance.
- **Full-width wrap:** ADD 0xFFFF_FFFF + 0x0000_0000, cin = 1 → sum 0, cout 1, zero 1, ovf 0. Then ADD 0x7FFF_FFFF + 1 → sum 0x8000_0000, ovf 1, cout 0.
- **SUB borrow and zero:** SUB 5 − 7 → 0xFFFF_FFFE, cout 0. SUB 7 − 7 → 0, cout 1, zero 1. SUB 0x8000_0000 − 1 → 0x7FFF_FFFF, ovf 1. in_cin = 1 must not change any of these results.
- **Back-pressure:** stream 6 back-to-back beats and hold out_ready = 0 for 3 cycles mid-stream → in_ready low during the stall, no beat lost or duplicated, output order matches input order, out_* stable while stalled.
- **Reset mid-flight:** assert rst_n = 0 with 3 beats in flight → all outputs 0 immediately. After release, the next beat's result is correct and none of the flushed beats are emitted.
- **Parameter sweep:** random operands against a reference model at (WIDTH, CHUNK) = (8, 8), (16, 4), (64, 16) → results match, and latency equals WIDTH/CHUNK.
